mips_multicycle_ctrl: RTL

- Multicycle sequencer for the MIPS datapath. One FSM drives every datapath enable and mux select: PC, instruction register, register file, ALU source muxes, the ALU-extension mux (sltu/lui/sll) and the shared instruction/data memory port.
- Replaces the single-cycle controller/maindec/aludec trio.
- Adds a memory-ready handshake so the datapath tolerates variable-latency memory.

---
 rtl/mips_multicycle_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer: one FSM drives every datapath enable/select; outputs are combinational from state.
// lw 5 cycles, sw/R/I-type 4, branch/jump 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR stalls exactly one cycle.
module mips_multicycle_ctrl #(
    parameter bit FETCH_ONLY_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memreq,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzext,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [1:0] aluext,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_LUIEXEC = 4'd12
    } state_t;

    state_t cur;
    state_t nxt;
    logic   armed;
    logic   fetch_go;
    logic   set_illegal;

    // With FETCH_ONLY_RESET=0 the first post-reset cycle sits in FETCH without a request.
    assign fetch_go = FETCH_ONLY_RESET || armed;
    assign state    = cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur     <= S_FETCH;
            illegal <= 1'b0;
            armed   <= 1'b0;
        end else begin
            cur   <= nxt;
            armed <= 1'b1;
            if (set_illegal) illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt         = S_FETCH;
        set_illegal = 1'b0;
        memreq      = 1'b0;
        iord        = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        pcen        = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        immzext     = 1'b0;
        pcsrc       = 2'b00;
        alucontrol  = 3'b010;
        aluext      = 2'b00;
        case (cur)
            S_FETCH: begin
                memreq = fetch_go;
                nxt    = S_FETCH;
                if (mem_ready && fetch_go) begin
                    irwrite = 1'b1;
                    alusrcb = 2'b01;
                    pcen    = 1'b1;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: nxt = S_MEMADR;
                    6'b000000:            nxt = S_EXECUTE;
                    6'b000100, 6'b000101: nxt = S_BRANCH;
                    6'b001000, 6'b001101: nxt = S_IEXEC;
                    6'b001111:            nxt = S_LUIEXEC;
                    6'b000010:            nxt = S_JUMP;
                    default: begin
                        set_illegal = 1'b1;
                        nxt         = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                memreq = 1'b1;
                iord   = 1'b1;
                nxt    = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memreq   = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                nxt     = S_ALUWB;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b100110: alucontrol = 3'b011;
                    6'b101010: alucontrol = 3'b111;
                    6'b101011: aluext     = 2'b01;
                    6'b000000: aluext     = 2'b11;
                    default: begin
                        set_illegal = 1'b1;
                        nxt         = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = (op == 6'b000100) ? zero : ~zero;
            end
            S_IEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = S_IWB;
                if (op == 6'b001101) begin
                    alucontrol = 3'b001;
                    immzext    = 1'b1;
                end
            end
            S_LUIEXEC: begin
                aluext = 2'b10;
                nxt    = S_IWB;
            end
            S_IWB: begin
                regwrite = 1'b1;
            end
            S_JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
        // Reset is asynchronous, so the write strobes must drop the instant it asserts.
        if (!reset) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule
